// File: rtl/tx_channel_mux.sv
// rtl/tx_channel_mux.sv - lane selector with fixed/round-robin channel choice and a registered valid/ready output
// Invalid channels load ERR_CODE with out_err set and bump a saturating error counter.
module tx_channel_mux #(
  parameter int                DATA_W   = 8,
  parameter int                N_CH     = 3,
  parameter int                CH_W     = 4,
  parameter logic [DATA_W-1:0] ERR_CODE = 8'hEE,
  parameter int                ERRCNT_W = 8
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   enable,
  input  logic                   mode,
  input  logic [CH_W-1:0]        channel,
  input  logic [N_CH*DATA_W-1:0] input_data,
  input  logic                   out_ready,
  input  logic                   clr_err,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [CH_W-1:0]        out_channel,
  output logic                   out_err,
  output logic [ERRCNT_W-1:0]    err_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [CH_W-1:0]     out_channel_q, out_channel_d;
  logic                out_err_q, out_err_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;

  logic                load;
  logic [CH_W-1:0]     sel;
  logic                sel_ok;
  logic [DATA_W-1:0]   lane_data;

  always_comb begin
    load      = enable & ((state_q == EMPTY) | out_ready);
    sel       = mode ? ptr_q : channel;
    sel_ok    = (sel != '0) && (sel <= CH_W'(N_CH));
    lane_data = '0;
    for (int k = 1; k <= N_CH; k++) begin
      if (sel == CH_W'(k)) lane_data = input_data[(k-1)*DATA_W +: DATA_W];
    end

    state_d       = state_q;
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    out_err_d     = out_err_q;
    err_cnt_d     = err_cnt_q;
    ptr_d         = ptr_q;

    if (load) begin
      state_d       = FULL;
      out_data_d    = sel_ok ? lane_data : ERR_CODE;
      out_channel_d = sel;
      out_err_d     = ~sel_ok;
      if (mode) ptr_d = (ptr_q == CH_W'(N_CH)) ? CH_W'(1) : ptr_q + CH_W'(1);
      if (!sel_ok && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERRCNT_W'(1);
    end else if ((state_q == FULL) && out_ready) begin
      // Accepted with enable low: drain; the last fields simply stay on the bus.
      state_d = EMPTY;
    end

    if (clr_err) err_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q       <= EMPTY;
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_err_q     <= 1'b0;
      err_cnt_q     <= '0;
      ptr_q         <= CH_W'(1);
    end else begin
      state_q       <= state_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_err_q     <= out_err_d;
      err_cnt_q     <= err_cnt_d;
      ptr_q         <= ptr_d;
    end
  end

  assign out_valid   = (state_q == FULL);
  assign out_data    = out_data_q;
  assign out_channel = out_channel_q;
  assign out_err     = out_err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_tx_channel_mux.sv
// tb/tb_tx_channel_mux.sv - directed vector bench for tx_channel_mux
// A second instance with a 2-bit error counter shares the stimulus for saturation.
module tb_tx_channel_mux;

  logic        clk = 1'b0;
  logic        arst;
  logic        enable, mode, out_ready, clr_err;
  logic [3:0]  channel;
  logic [23:0] input_data;

  logic        out_valid, out_err;
  logic [7:0]  out_data, err_cnt;
  logic [3:0]  out_channel;

  logic        out_valid2, out_err2;
  logic [7:0]  out_data2;
  logic [3:0]  out_channel2;
  logic [1:0]  err_cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tx_channel_mux u_dut (
    .clk(clk), .arst(arst), .enable(enable), .mode(mode), .channel(channel),
    .input_data(input_data), .out_ready(out_ready), .clr_err(clr_err),
    .out_valid(out_valid), .out_data(out_data), .out_channel(out_channel),
    .out_err(out_err), .err_cnt(err_cnt)
  );

  tx_channel_mux #(.ERRCNT_W(2)) u_dut2 (
    .clk(clk), .arst(arst), .enable(enable), .mode(mode), .channel(channel),
    .input_data(input_data), .out_ready(out_ready), .clr_err(clr_err),
    .out_valid(out_valid2), .out_data(out_data2), .out_channel(out_channel2),
    .out_err(out_err2), .err_cnt(err_cnt2)
  );

  typedef struct {
    logic       en;
    logic       md;
    logic [3:0] ch;
    logic       rdy;
    logic       clr;
    logic       v;
    logic [7:0] d;
    logic [3:0] oc;
    logic       e;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic en, logic md, logic [3:0] ch, logic rdy, logic clr,
                              logic v, logic [7:0] d, logic [3:0] oc, logic e, logic [7:0] cnt);
    vec_t r;
    r.en = en; r.md = md; r.ch = ch; r.rdy = rdy; r.clr = clr;
    r.v = v; r.d = d; r.oc = oc; r.e = e; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic md, input logic [3:0] ch,
                       input logic rdy, input logic clr);
    enable = en; mode = md; channel = ch; out_ready = rdy; clr_err = clr;
  endtask

  initial begin
    // en md ch rdy clr | valid data och err cnt
    tbl.push_back(mk(0,0, 1,1,0, 0,8'h00, 0,0,0));  // enable low: stays empty
    tbl.push_back(mk(1,0, 1,1,0, 1,8'h11, 1,0,0));
    tbl.push_back(mk(1,0, 2,1,0, 1,8'h22, 2,0,0));
    tbl.push_back(mk(1,0, 3,1,0, 1,8'h33, 3,0,0));
    tbl.push_back(mk(1,0, 0,1,0, 1,8'hEE, 0,1,1));
    tbl.push_back(mk(1,0, 4,1,0, 1,8'hEE, 4,1,2));
    tbl.push_back(mk(1,0,15,1,1, 1,8'hEE,15,1,0));  // clr beats increment
    tbl.push_back(mk(0,0, 1,1,0, 0,8'h00, 0,0,0));  // accept, drain
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(1,1, 0,1,0, 1, 8'h11 * ((i % 3) + 1), 4'((i % 3) + 1), 0, 0));
    tbl.push_back(mk(1,0, 3,1,0, 1,8'h33, 3,0,0));  // fixed load keeps pointer at 2
    tbl.push_back(mk(1,1, 0,1,0, 1,8'h22, 2,0,0));  // scan resumes at 2
    tbl.push_back(mk(1,1, 0,0,0, 1,8'h22, 2,0,0));  // stalled
    tbl.push_back(mk(1,0, 1,0,0, 1,8'h22, 2,0,0));  // input changes ignored
    tbl.push_back(mk(1,1, 2,0,0, 1,8'h22, 2,0,0));
    tbl.push_back(mk(1,1, 0,1,0, 1,8'h33, 3,0,0));  // pointer was not moved by stall
    tbl.push_back(mk(0,1, 0,1,0, 0,8'h00, 0,0,0));
    tbl.push_back(mk(1,1, 0,0,0, 1,8'h11, 1,0,0));  // load from EMPTY with ready low
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1,1, 0,0,0, 1,8'h11, 1,0,0));
    tbl.push_back(mk(1,1, 0,1,0, 1,8'h22, 2,0,0));
    tbl.push_back(mk(0,0, 0,0,0, 1,8'h22, 2,0,0));  // disable while stalled: hold
    tbl.push_back(mk(0,0, 0,0,0, 1,8'h22, 2,0,0));
    tbl.push_back(mk(0,0, 0,1,0, 0,8'h00, 0,0,0));  // accepted, then empty

    input_data = 24'h332211;
    arst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      input_data = 24'($urandom);
      tick();
      chk("reset_valid", out_valid, 0);
      chk("reset_data", out_data, 0);
      chk("reset_errcnt", err_cnt, 0);
    end
    chk("reset_channel", out_channel, 0);
    chk("reset_err", out_err, 0);
    input_data = 24'h332211;
    drive(0,0,1,1,0);
    tick();
    arst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].md, tbl[i].ch, tbl[i].rdy, tbl[i].clr);
      tick();
      chk($sformatf("vec%0d_valid", i), out_valid, tbl[i].v);
      chk($sformatf("vec%0d_errcnt", i), err_cnt, tbl[i].cnt);
      if (tbl[i].v) begin
        chk($sformatf("vec%0d_data", i), out_data, tbl[i].d);
        chk($sformatf("vec%0d_chan", i), out_channel, tbl[i].oc);
        chk($sformatf("vec%0d_err", i), out_err, tbl[i].e);
      end
    end

    // Saturation: five error loads, 8-bit counter reaches 5, 2-bit counter sticks at 3.
    drive(1,0,0,1,1);
    tick();
    for (int i = 1; i <= 5; i++) begin
      drive(1,0,0,1,0);
      tick();
      chk($sformatf("sat%0d_cnt8", i), err_cnt, i);
      chk($sformatf("sat%0d_cnt2", i), err_cnt2, (i > 3) ? 3 : i);
      chk($sformatf("sat%0d_err2", i), out_err2, 1);
    end

    // Asynchronous reset mid-transfer discards the held sample.
    drive(1,0,2,0,0);
    tick();
    chk("pre_rst_valid", out_valid, 1);
    #2 arst = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_chan", out_channel, 0);
    chk("arst_errcnt", err_cnt, 0);
    chk("arst_errcnt2", err_cnt2, 0);
    drive(0,1,0,1,0);
    tick();
    arst = 1'b1;
    tick();
    chk("post_rst_idle", out_valid, 0);
    drive(1,1,0,1,0);
    tick();
    chk("post_rst_ptr", out_channel, 1);
    chk("post_rst_data", out_data, 8'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_channel_mux.md
Name: tx_channel_mux

Overview:
Parametrised successor of the transmitter's byte-lane input selector. It selects one DATA_W lane out of N_CH packed input lanes and registers it into a valid/ready output stage toward the transmitter framer. A lane is chosen either by an explicit channel number (fixed mode) or by an internal round-robin scan pointer (scan mode). Invalid channel numbers produce a flagged error code, and a saturating error counter records them.

Parameters:
DATA_W, 8, width of one lane and of out_data
N_CH, 3, number of input lanes; legal channels are 1..N_CH
CH_W, 4, width of channel, out_channel and scan pointer; 2**CH_W > N_CH
ERR_CODE, 8'hEE, value driven on out_data for an invalid channel (DATA_W bits)
ERRCNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  clock, all state on rising edge
arst  in  1  asynchronous active-low reset
enable  in  1  allow new samples to be loaded
mode  in  1  0 = fixed channel, 1 = round-robin scan
channel  in  CH_W  requested channel in fixed mode (1-based)
input_data  in  N_CH*DATA_W  packed lanes; lane k (1-based) = bits [k*DATA_W-1:(k-1)*DATA_W]
out_ready  in  1  downstream accepts out_data this cycle
clr_err  in  1  synchronous clear of err_cnt
out_valid  out  1  out_data/out_channel/out_err hold a sample
out_data  out  DATA_W  selected lane or ERR_CODE
out_channel  out  CH_W  channel number the sample came from
out_err  out  1  sample is an invalid-channel error
err_cnt  out  ERRCNT_W  count of error samples loaded, saturating

Behaviour:
- Reset (arst low, asynchronous): out_valid=0, out_data=0, out_channel=0, out_err=0, err_cnt=0, scan pointer=1, state EMPTY. Reset mid-transfer discards the held sample.
- States: EMPTY (out_valid=0) and FULL (out_valid=1). out_valid is a direct decode of the state.
- accept = out_valid & out_ready. load = enable & (!out_valid | out_ready).
- EMPTY: load -> FULL; otherwise stay in EMPTY.
- FULL: load (enable & out_ready) -> FULL with the new sample (back-to-back, one sample per cycle). accept & !enable -> EMPTY. !out_ready -> hold all output fields stable, with no load and no pointer move.
- Latency: the sample is taken from input_data/channel/mode in the load cycle and appears on the outputs in the next cycle.
- Selected channel sel = mode ? scan pointer : channel.
- Valid sel (1..N_CH): out_data = lane sel, out_err = 0.
- Invalid sel (0 or > N_CH): out_data = ERR_CODE, out_err = 1.
- In every case out_channel = sel.
- Scan pointer advances only on a load with mode=1: N_CH wraps to 1, otherwise it increments by 1. Fixed-mode loads leave the pointer unchanged. Switching from mode 0 to mode 1 resumes from the retained pointer.
- err_cnt increments by 1 on each load with an invalid sel and saturates at 2**ERRCNT_W-1.
- clr_err sets err_cnt to 0 and has priority over a simultaneous increment.
- Deasserting enable while FULL and stalled keeps the sample until it is accepted, then goes EMPTY.
- Changes on the input_data/channel/mode ports while stalled have no effect.

Test Plan:
- Reset: hold arst=0 with random inputs -> out_valid=0, out_data=0, err_cnt=0. Release arst, enable=0 -> out_valid stays 0.
- Fixed mode: N_CH=3, input_data=24'h332211, out_ready=1, channel=1,2,3 on consecutive cycles -> out_data=11,22,33, each one cycle later, out_err=0, back-to-back out_valid=1.
- Error path: channel=0 then channel=4, out_ready=1 -> out_data=EE twice with out_err=1, out_channel=0 then 4, err_cnt=2. Pulse clr_err in the cycle of a third error -> err_cnt=0.
- Scan mode: mode=1, out_ready=1 for 7 cycles -> out_channel=1,2,3,1,2,3,1 and out_data=11,22,33,11,22,33,11.
- Back-pressure: scan mode, out_ready=0 for 4 cycles after the first sample -> out_data=11 and out_channel=1 stay stable and the pointer does not move. On out_ready=1 the next sample is 22.
- Saturation and disable: ERRCNT_W=2, 5 error loads -> err_cnt=3. Deassert enable while FULL with out_ready=0 -> held until accept, then out_valid=0.
